// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div sequencer owning HI/LO.
// Issues from E-stage, holds busy for a fixed latency, then retires.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;
  logic [31:0]   hi_n, lo_n;
  logic          ld;

  logic          is_md;
  logic [63:0]   res;
  logic          res_ok;

  assign is_md = ~md_op[2];
  assign busy  = (state == RUN);

  // reset gates the registered busy so stall drops while in reset
  assign md_stall = (busy & reset) | (start & is_md);

  // compute the retiring result from the latched operands
  always_comb begin
    logic [63:0] ea, eb;
    logic [31:0] am, bm, bs, q, r;
    logic        sa, sb;
    res    = '0;
    res_ok = 1'b0;
    ea     = '0;
    eb     = '0;
    sa     = 1'b0;
    sb     = 1'b0;
    am     = a_q;
    bm     = b_q;
    bs     = 32'd1;
    q      = '0;
    r      = '0;
    unique case (1'b1)
      (op_q == OP_MULT): begin
        ea     = {{32{a_q[31]}}, a_q};
        eb     = {{32{b_q[31]}}, b_q};
        res    = ea * eb;
        res_ok = 1'b1;
      end
      (op_q == OP_MULTU): begin
        ea     = {32'd0, a_q};
        eb     = {32'd0, b_q};
        res    = ea * eb;
        res_ok = 1'b1;
      end
      (op_q == OP_DIV),
      (op_q == OP_DIVU): begin
        sa = (op_q == OP_DIV) & a_q[31];
        sb = (op_q == OP_DIV) & b_q[31];
        am = sa ? (~a_q + 32'd1) : a_q;
        bm = sb ? (~b_q + 32'd1) : b_q;
        bs = (bm == 32'd0) ? 32'd1 : bm;
        q  = am / bs;
        r  = am % bs;
        if (sa ^ sb) q = ~q + 32'd1;
        if (sa)      r = ~r + 32'd1;
        res    = {r, q};
        res_ok = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  // next-state, counter and HI/LO update decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    ld      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_md: begin
              ld      = 1'b1;
              state_n = RUN;
              cnt_n   = md_op[1] ? CW'(DIV_CYCLES)
                                 : CW'(MULT_CYCLES);
            end
            (md_op == OP_MTHI): hi_n = rs_val;
            (md_op == OP_MTLO): lo_n = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (res_ok) begin
            hi_n = res[63:32];
            lo_n = res[31:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, counter, operand latch and HI/LO registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (ld) begin
        a_q  <= rs_val;
        b_q  <= rt_val;
        op_q <= md_op;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed checks of md_sequencer latency,
// arithmetic results, HI/LO moves, ignored starts and reset abort.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int ncmp = 0;
  int nbad = 0;

  md_sequencer #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .md_stall(md_stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    #1;
    tick();
    start  = 1'b0;
    md_op  = 3'd6;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      rs_val = $urandom;
      rt_val = $urandom;
    end
  endtask

  int n;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = 3'd6;
    rs_val = '0;
    rt_val = '0;
    #1;
    chk("stall_in_reset", 64'(md_stall), 64'd0);
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    tick();

    // mult -2 * 3
    start = 1'b1; md_op = 3'd0;
    rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    #1;
    chk("mult_stall_comb", 64'(md_stall), 64'd1);
    start = 1'b0;
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_busy_on", 64'(busy), 64'd1);
    wait_idle(n);
    chk("mult_cycles", 64'(n), 64'd5);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // multu
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    chk("multu_cycles", 64'(n), 64'd5);
    chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    // div -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    chk("div_cycles", 64'(n), 64'd10);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // divu by zero leaves hi/lo
    issue(3'd3, 32'd7, 32'd0);
    chk("div0_busy", 64'(busy), 64'd1);
    wait_idle(n);
    chk("div0_cycles", 64'(n), 64'd10);
    chk("div0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // signed overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // divu 100 / 7
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // signed div, negative divisor: 7 / -2
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    chk("div_negb_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    // mthi then mtlo
    start = 1'b1; md_op = 3'd4; rs_val = 32'h1234_5678;
    #1;
    chk("mthi_stall", 64'(md_stall), 64'd0);
    tick();
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);
    md_op = 3'd5; rs_val = 32'h9ABC_DEF0;
    #1;
    chk("mtlo_stall", 64'(md_stall), 64'd0);
    tick();
    start = 1'b0;
    chk("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    chk("mtlo_busy", 64'(busy), 64'd0);

    // no-op ops change nothing
    start = 1'b1; md_op = 3'd6; rs_val = 32'hDEAD_BEEF;
    tick();
    md_op = 3'd7;
    #1;
    chk("noop_stall", 64'(md_stall), 64'd0);
    tick();
    start = 1'b0;
    chk("noop_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    chk("noop_busy", 64'(busy), 64'd0);

    // starts during RUN are ignored
    issue(3'd0, 32'd3, 32'd4);
    tick();
    start = 1'b1; md_op = 3'd5; rs_val = 32'hDEAD_BEEF;
    tick();
    md_op = 3'd2; rs_val = 32'd99; rt_val = 32'd1;
    tick();
    start = 1'b0;
    chk("run_stall", 64'(md_stall), 64'd1);
    wait_idle(n);
    chk("ign_cycles", 64'(n + 3), 64'd5);
    chk("ign_hilo", {hi, lo}, 64'h0000_0000_0000_000C);

    // reset mid-div aborts, no later write
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    chk("abort_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_stall", 64'(md_stall), 64'd0);
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    repeat (15) tick();
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_hilo", {hi, lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
